// File: rtl/wb_slave_ctrl.sv
// ---------------------------------------------------------------------------
// wb_slave_ctrl
//
// Wishbone B3 classic-cycle slave that bridges the bus to a word-addressed
// synchronous memory with one cycle of read latency. It adds configurable
// wait states, byte-lane selects, address-range decode with error
// termination, abort when the master drops the cycle, and a registered
// read-data path.
//
// Parameters
//   ADDR_W      Wishbone byte-address width
//   DATA_W      data width, multiple of 8 (SEL_W = DATA_W/8 byte lanes)
//   MEM_AW      memory word-address width (2^MEM_AW words)
//   BASE_ADDR   slave base; bits [ADDR_W-1:MEM_AW+OFS] are decoded
//   WAIT_CYCLES wait states inserted before the memory access (0..15)
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   wb_cyc_i, wb_stb_i         bus cycle valid / strobe
//   wb_we_i                    1 = write
//   wb_adr_i, wb_sel_i         byte address / byte-lane selects
//   wb_dat_i, wb_dat_o         write data / registered read data
//   wb_ack_o, wb_err_o         normal / error termination (one cycle each)
//   mem_adr_o                  latched word address
//   mem_we_o                   per-byte write enables (one-cycle pulse)
//   mem_re_o                   read enable (one-cycle pulse)
//   mem_wdat_o                 latched write data
//   mem_rdat_i                 read data, valid one cycle after mem_re_o
//   busy_o                     high whenever the FSM is not idle
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no transfer; sample cyc & stb, decode address and selects
// ADR    | request latched; load wait counter
// WAIT   | count wait states down; frozen while stb is low
// ACCESS | one-cycle memory strobe (write enables or read enable)
// RLAT   | memory read latency; capture masked read data
// ACK    | one-cycle normal termination
// ERR    | one-cycle error termination, no memory strobe
// ---------------------------------------------------------------------------
module wb_slave_ctrl #(
    parameter int                 ADDR_W      = 32,
    parameter int                 DATA_W      = 32,
    parameter int                 MEM_AW      = 10,
    parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
    parameter int                 WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_W-1:0]     wb_adr_i,
    input  logic [DATA_W/8-1:0]   wb_sel_i,
    input  logic [DATA_W-1:0]     wb_dat_i,
    output logic [DATA_W-1:0]     wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic [MEM_AW-1:0]     mem_adr_o,
    output logic [DATA_W/8-1:0]   mem_we_o,
    output logic                  mem_re_o,
    output logic [DATA_W-1:0]     mem_wdat_o,
    input  logic [DATA_W-1:0]     mem_rdat_i,
    output logic                  busy_o
);

    localparam int SEL_W   = DATA_W / 8;
    localparam int OFS     = $clog2(SEL_W);
    localparam int DEC_LSB = MEM_AW + OFS;

    localparam logic [3:0] WAIT_LD  = 4'(WAIT_CYCLES);
    localparam bit         HAS_WAIT = (WAIT_CYCLES != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADR    = 3'd1,
        S_WAIT   = 3'd2,
        S_ACCESS = 3'd3,
        S_RLAT   = 3'd4,
        S_ACK    = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [3:0]          r_wait_cnt;
    logic [MEM_AW-1:0]   r_adr;
    logic [SEL_W-1:0]    r_sel;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdat;
    logic [DATA_W-1:0]   r_dat_o;

    logic                w_req;
    logic                w_hit;
    logic                w_sel_any;
    logic                w_accept;
    logic [DATA_W-1:0]   w_lane_mask;

    // Byte-offset address bits never reach the word-addressed memory.
    if (OFS > 0) begin : g_unused_ofs
        logic w_unused_ofs;
        assign w_unused_ofs = ^wb_adr_i[OFS-1:0];
    end

    assign w_req     = wb_cyc_i & wb_stb_i;
    assign w_hit     = (wb_adr_i[ADDR_W-1:DEC_LSB] == BASE_ADDR[ADDR_W-1:DEC_LSB]);
    assign w_sel_any = |wb_sel_i;
    assign w_accept  = (r_state == S_IDLE) && w_req && w_hit && w_sel_any;

    always_comb begin
        w_lane_mask = '0;
        for (int i = 0; i < SEL_W; i++) begin
            w_lane_mask[8*i +: 8] = {8{r_sel[i]}};
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A dropped cycle aborts ADR/WAIT/RLAT; ACCESS,
    // ACK and ERR always run to completion so a strobe that has been
    // issued is always terminated consistently.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_hit && w_sel_any) begin
                        w_state_nxt = S_ADR;
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end
            end
            S_ADR: begin
                if (!wb_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (wb_stb_i) begin
                    w_state_nxt = HAS_WAIT ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (!wb_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (wb_stb_i && (r_wait_cnt <= 4'd1)) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_state_nxt = r_we ? S_ACK : S_RLAT;
            end
            S_RLAT: begin
                w_state_nxt = wb_cyc_i ? S_ACK : S_IDLE;
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            S_ERR: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Wait counter: loaded in ADR, counts down in WAIT only while the
    // master keeps stb high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= 4'd0;
        end else if (r_state == S_ADR) begin
            r_wait_cnt <= WAIT_LD;
        end else if ((r_state == S_WAIT) && wb_cyc_i && wb_stb_i && (r_wait_cnt != 4'd0)) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Request latch. Captured on the edge that moves IDLE to ADR so that
    // address and write data are already stable during ADR and stay put
    // until the next accepted request.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_adr  <= '0;
            r_sel  <= '0;
            r_we   <= 1'b0;
            r_wdat <= '0;
        end else if (w_accept) begin
            r_adr  <= wb_adr_i[DEC_LSB-1:OFS];
            r_sel  <= wb_sel_i;
            r_we   <= wb_we_i;
            r_wdat <= wb_dat_i;
        end
    end

    // ------------------------------------------------------------------
    // Registered read data; unselected lanes read as zero. Only updated
    // when the read is about to be acknowledged.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dat_o <= '0;
        end else if ((r_state == S_RLAT) && wb_cyc_i) begin
            r_dat_o <= mem_rdat_i & w_lane_mask;
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs decoded from the state register
    // ------------------------------------------------------------------
    always_comb begin
        mem_we_o = '0;
        mem_re_o = 1'b0;
        if (r_state == S_ACCESS) begin
            if (r_we) begin
                mem_we_o = r_sel;
            end else begin
                mem_re_o = 1'b1;
            end
        end
    end

    assign wb_ack_o   = (r_state == S_ACK);
    assign wb_err_o   = (r_state == S_ERR);
    assign busy_o     = (r_state != S_IDLE);
    assign wb_dat_o   = r_dat_o;
    assign mem_adr_o  = r_adr;
    assign mem_wdat_o = r_wdat;

endmodule

// File: tb/tb_wb_slave_ctrl.sv
module tb_wb_slave_ctrl;

    localparam int          W     = 2;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          LIMIT = 24;

    logic        clk;
    logic        reset;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [9:0]  mem_adr_o;
    logic [3:0]  mem_we_o;
    logic        mem_re_o;
    logic [31:0] mem_wdat_o;
    logic [31:0] mem_rdat_i;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;

    int n_we_pulse = 0;
    int n_re_pulse = 0;
    int n_overlap  = 0;

    logic [31:0] env_mem [0:1023];
    logic [31:0] model [int];
    logic [31:0] last_rd;

    wb_slave_ctrl #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MEM_AW      (10),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_sel_i   (wb_sel_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .mem_adr_o  (mem_adr_o),
        .mem_we_o   (mem_we_o),
        .mem_re_o   (mem_re_o),
        .mem_wdat_o (mem_wdat_o),
        .mem_rdat_i (mem_rdat_i),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple synchronous memory with one cycle of read latency.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we_o[b]) env_mem[mem_adr_o][8*b +: 8] <= mem_wdat_o[8*b +: 8];
        end
        if (mem_re_o) mem_rdat_i <= env_mem[mem_adr_o];
    end

    always @(negedge clk) begin
        if (mem_we_o != 4'd0) n_we_pulse++;
        if (mem_re_o)         n_re_pulse++;
        if (wb_ack_o && wb_err_o) n_overlap++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input int idx);
        return model.exists(idx) ? model[idx] : 32'h0;
    endfunction

    task automatic idle_bus();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = '0;
        wb_sel_i = '0;
        wb_dat_i = '0;
    endtask

    // One complete Wishbone transfer, called #1 after a rising edge.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input string tag);
        int          c_we, c_re, c_ack, c_err, we0, re0;
        logic [3:0]  we_val;
        logic [9:0]  adr_seen;
        logic [31:0] wd_seen, rd_seen, mask, exp_rd, upd;
        logic        adr_ok, hit, is_err;
        int          widx;

        hit    = (adr[31:12] == BASE[31:12]);
        is_err = !hit || (sel == 4'd0);
        widx   = int'(adr[11:2]);
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{sel[b]}};

        chk({tag, ":start_idle"}, busy_o, 0);
        we0 = n_we_pulse; re0 = n_re_pulse;
        c_we = -1; c_re = -1; c_ack = -1; c_err = -1;
        we_val = '0; adr_seen = '0; wd_seen = '0; rd_seen = '0; adr_ok = 1'b1;

        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;

        for (int k = 1; k <= LIMIT && c_ack < 0 && c_err < 0; k++) begin
            @(posedge clk); #1;
            if (mem_we_o != 4'd0 && c_we < 0) begin
                c_we = k; we_val = mem_we_o; adr_seen = mem_adr_o; wd_seen = mem_wdat_o;
            end
            if (mem_re_o && c_re < 0) begin
                c_re = k; adr_seen = mem_adr_o;
            end
            if (!is_err && (mem_adr_o != widx[9:0] || (we && mem_wdat_o != dat))) adr_ok = 1'b0;
            if (wb_ack_o) begin c_ack = k; rd_seen = wb_dat_o; end
            if (wb_err_o) c_err = k;
        end
        idle_bus();
        @(posedge clk); #1;
        chk({tag, ":one_cycle_term"}, {wb_ack_o, wb_err_o}, 2'b00);
        chk({tag, ":back_idle"}, busy_o, 0);

        if (is_err) begin
            chk({tag, ":err_cyc"}, c_err, 1);
            chk({tag, ":no_ack"}, c_ack, -1);
            chk({tag, ":strobes"}, {n_we_pulse - we0, n_re_pulse - re0}, 64'd0);
        end else if (we) begin
            chk({tag, ":we_cyc"}, c_we, 2 + W);
            chk({tag, ":ack_cyc"}, c_ack, 3 + W);
            chk({tag, ":we_val"}, we_val, sel);
            chk({tag, ":mem_adr"}, adr_seen, widx[9:0]);
            chk({tag, ":wdat"}, wd_seen, dat);
            chk({tag, ":stable"}, adr_ok, 1);
            chk({tag, ":we_pulses"}, n_we_pulse - we0, 1);
            chk({tag, ":re_pulses"}, n_re_pulse - re0, 0);
            upd = model_rd(widx);
            upd = (upd & ~mask) | (dat & mask);
            model[widx] = upd;
        end else begin
            exp_rd = model_rd(widx) & mask;
            chk({tag, ":re_cyc"}, c_re, 2 + W);
            chk({tag, ":ack_cyc"}, c_ack, 4 + W);
            chk({tag, ":mem_adr"}, adr_seen, widx[9:0]);
            chk({tag, ":rdata"}, rd_seen, exp_rd);
            chk({tag, ":stable"}, adr_ok, 1);
            chk({tag, ":re_pulses"}, n_re_pulse - re0, 1);
            chk({tag, ":we_pulses"}, n_we_pulse - we0, 0);
            last_rd = exp_rd;
        end
        chk({tag, ":dat_o_hold"}, wb_dat_o, last_rd);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        int          kind, we0;

        for (int i = 0; i < 1024; i++) env_mem[i] = 32'h0;
        last_rd = 32'h0;
        idle_bus();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {busy_o, wb_ack_o, wb_err_o, mem_we_o, mem_re_o, mem_adr_o, mem_wdat_o, wb_dat_o}, 0);
        reset = 1'b0;

        // Directed: first request right after reset release
        xfer(1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, "wr_full");
        xfer(1'b0, BASE + 32'h10, 4'hF, 32'h0,         "rd_full");
        xfer(1'b1, BASE + 32'h10, 4'b0010, 32'h0000_AB00, "wr_lane1");
        xfer(1'b0, BASE + 32'h10, 4'hF, 32'h0,         "rd_after_lane");
        chk("lane_value", last_rd, 32'hDEAD_ABEF);
        xfer(1'b0, BASE + 32'h10, 4'b0001, 32'h0,      "rd_lane0");
        chk("lane0_value", last_rd, 32'h0000_00EF);

        // Error paths
        xfer(1'b1, BASE + 32'h1000, 4'hF, 32'h1111_2222, "err_range");
        xfer(1'b0, BASE - 32'h4,    4'hF, 32'h0,         "err_below");
        xfer(1'b1, BASE + 32'h14,   4'h0, 32'h3333_4444, "err_sel0");

        // Randomised transfers
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            a = BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            s = 4'($urandom_range(1, 15));
            d = $urandom;
            if (kind == 0) a = a ^ (32'h1 << $urandom_range(12, 31));
            if (kind == 1) s = 4'h0;
            xfer(1'($urandom_range(0, 1)), a, s, d, $sformatf("rnd%0d", n));
        end

        // Abort: drop cyc in the second WAIT cycle of a write
        xfer(1'b1, BASE + 32'h40, 4'hF, 32'hA5A5_0001, "abort_pre");
        we0 = n_we_pulse;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = BASE + 32'h40; wb_sel_i = 4'hF; wb_dat_i = 32'h1234_5678;
        repeat (W + 1) @(posedge clk);
        #1;
        chk("abort_busy_wait", busy_o, 1);
        idle_bus();
        @(posedge clk); #1;
        chk("abort_idle", busy_o, 0);
        chk("abort_noterm", {wb_ack_o, wb_err_o}, 2'b00);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_we", n_we_pulse - we0, 0);
        xfer(1'b0, BASE + 32'h40, 4'hF, 32'h0, "abort_readback");
        chk("abort_old_data", last_rd, 32'hA5A5_0001);

        // Asynchronous reset during WAIT of a write
        we0 = n_we_pulse;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = BASE + 32'h40; wb_sel_i = 4'hF; wb_dat_i = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_async_outs", {busy_o, wb_ack_o, wb_err_o, mem_we_o, mem_re_o, mem_adr_o, mem_wdat_o, wb_dat_o}, 0);
        idle_bus();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        last_rd = 32'h0;
        chk("rst_no_we", n_we_pulse - we0, 0);
        xfer(1'b0, BASE + 32'h40, 4'hF, 32'h0, "rst_readback");
        chk("rst_old_data", last_rd, 32'hA5A5_0001);
        xfer(1'b1, BASE + 32'h44, 4'b1100, 32'h7788_9900, "rst_wr");
        xfer(1'b0, BASE + 32'h44, 4'hF, 32'h0, "rst_rd");

        chk("ack_err_exclusive", n_overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
